// File: rtl/stopwatch_run_controller.sv
// Button conditioning (sync, debounce, rising-edge) feeding a STOP/RUN/CLEAR
// sequencer that steps a 0..9999 up/down counter on a prescaled tick.
module stopwatch_run_controller #(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned TICK_DIV  = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run_stop,
  input  logic        btn_clear,
  input  logic        btn_mode,
  output logic [13:0] counter,
  output logic        running,
  output logic        mode_down,
  output logic        tick
);

  localparam int unsigned DW = $clog2(DB_CYCLES);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DB_MAX    = DW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [13:0]   COUNT_MAX = 14'd9999;

  typedef enum logic [1:0] {
    STOP,
    RUN,
    CLEAR
  } state_t;

  state_t state, state_next;

  logic [2:0]    raw, sync_a, sync_b, level, level_q, press;
  logic [DW-1:0] db_cnt [3];
  logic [PW-1:0] presc;
  logic [13:0]   count_next;
  logic          run_press, clear_press, mode_press;
  logic          stay_run, wrap;

  // Bit order: 0 = run/stop, 1 = clear, 2 = mode.
  assign raw = {btn_mode, btn_clear, btn_run_stop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level   <= '0;
      level_q <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_q <= level;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync_b[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          level[i]  <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign press       = level & ~level_q;
  assign run_press   = press[0];
  assign clear_press = press[1];
  assign mode_press  = press[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STOP;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      STOP: begin
        if (clear_press)    state_next = CLEAR;
        else if (run_press) state_next = RUN;
      end
      RUN: begin
        if (run_press) state_next = STOP;
      end
      CLEAR:   state_next = STOP;
      default: state_next = STOP;
    endcase
  end

  // A step is only taken when RUN is held across the edge, so leaving RUN
  // suppresses a coincident tick.
  assign stay_run = (state == RUN) && (state_next == RUN);
  assign wrap     = stay_run && (presc == PRESC_MAX);
  assign running  = (state == RUN);

  always_comb begin
    count_next = counter;
    if (mode_down) count_next = (counter == '0) ? COUNT_MAX : counter - 14'd1;
    else           count_next = (counter == COUNT_MAX) ? '0 : counter + 14'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      presc     <= '0;
      tick      <= 1'b0;
      mode_down <= 1'b0;
    end else begin
      tick <= wrap;
      if (mode_press) mode_down <= ~mode_down;
      if (state == CLEAR) begin
        counter <= '0;
        presc   <= '0;
      end else if (stay_run) begin
        presc <= wrap ? '0 : presc + PW'(1);
        if (wrap) counter <= count_next;
      end else begin
        presc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_run_controller.sv
// Scoreboarded bench: tasks push expected counter values per step, a monitor
// pops and compares them on every tick pulse.
module tb_stopwatch_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_run_stop = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_mode = 1'b0;
  logic [13:0] counter;
  logic        running, mode_down, tick;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int mon_exp;
  int exp_count = 0;
  bit exp_down = 1'b0;

  localparam logic [2:0] B_RUN  = 3'b001;
  localparam logic [2:0] B_CLR  = 3'b010;
  localparam logic [2:0] B_MODE = 3'b100;

  always #5 clk = ~clk;

  stopwatch_run_controller #(
    .DB_CYCLES(4),
    .TICK_DIV (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_run_stop(btn_run_stop),
    .btn_clear   (btn_clear),
    .btn_mode    (btn_mode),
    .counter     (counter),
    .running     (running),
    .mode_down   (mode_down),
    .tick        (tick)
  );

  always @(negedge clk) begin
    if (tick === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_tick: counter=%0d, no step expected", counter);
      end else begin
        mon_exp = exp_q.pop_front();
        if (counter !== 14'(mon_exp)) begin
          miscompares++;
          $display("FAIL tick_value: counter=%0d expected %0d", counter, mon_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int step_val(input int v, input bit down);
    if (down) return (v == 0) ? 9999 : v - 1;
    return (v == 9999) ? 0 : v + 1;
  endfunction

  task automatic set_btns(input logic [2:0] m);
    {btn_mode, btn_clear, btn_run_stop} = m;
  endtask

  // Hold for 7 cycles: press lands after 6, state changes after 7.
  task automatic pulse(input logic [2:0] m);
    set_btns(m);
    repeat (7) @(negedge clk);
    set_btns(3'b000);
  endtask

  task automatic run_then_stop(input int n, input logic [2:0] stop_mask, input string name);
    int v;
    pulse(B_RUN);
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_start: running=%b expected 1", name, running);
    end
    v = exp_count;
    for (int i = 0; i < n; i++) begin
      v = step_val(v, exp_down);
      exp_q.push_back(v);
    end
    // Stop lands exactly on the edge of the (n+1)th step, which must be suppressed.
    repeat (5 * n - 2) @(negedge clk);
    pulse(stop_mask);
    exp_count = v;
    vectors++;
    if (running !== 1'b0 || tick !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_stop: running=%b tick=%b expected 0 0", name, running, tick);
    end
    vectors++;
    if (counter !== 14'(v)) begin
      miscompares++;
      $display("FAIL %s_hold: counter=%0d expected %0d", name, counter, v);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_missing_ticks: pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (counter !== 14'd0 || running !== 1'b0 || mode_down !== 1'b0 || tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: counter=%0d running=%b mode_down=%b tick=%b expected 0 0 0 0",
               counter, running, mode_down, tick);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_run_press;
    int el;
    int guard;
    btn_run_stop = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        vectors++;
        if (running !== 1'b0) begin
          miscompares++;
          $display("FAIL run_latency_early: running=%b expected 0", running);
        end
      end
      if (k == 7) begin
        vectors++;
        if (running !== 1'b1) begin
          miscompares++;
          $display("FAIL run_latency: running=%b expected 1", running);
        end
      end
    end
    for (int i = 1; i <= 4; i++) exp_q.push_back(i);
    repeat (3) @(negedge clk);
    btn_run_stop = 1'b0;
    el = 3;
    for (int t = 1; t <= 3; t++) begin
      guard = 0;
      do begin
        @(negedge clk);
        el++;
        guard++;
      end while (tick !== 1'b1 && guard < 10);
      vectors++;
      if (el !== 5 * t) begin
        miscompares++;
        $display("FAIL tick_spacing: step %0d at cycle %0d expected %0d", t, el, 5 * t);
      end
    end
    pulse(B_RUN);
    exp_count = 4;
    vectors++;
    if (running !== 1'b0 || counter !== 14'd4) begin
      miscompares++;
      $display("FAIL run_stop: running=%b counter=%0d expected 0 4", running, counter);
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL run_missing_ticks: pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bounce;
    bit seen_run;
    seen_run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn_run_stop = ((i >> 1) & 1) == 0;
      @(negedge clk);
      if (running === 1'b1) seen_run = 1'b1;
    end
    btn_run_stop = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (running === 1'b1) seen_run = 1'b1;
    end
    vectors++;
    if (seen_run !== 1'b0 || counter !== 14'(exp_count)) begin
      miscompares++;
      $display("FAIL bounce: running_seen=%b counter=%0d expected 0 %0d", seen_run, counter, exp_count);
    end
  endtask

  task automatic test_clear_stop;
    run_then_stop(119, B_RUN, "to123");
    pulse(B_CLR);
    vectors++;
    if (counter !== 14'd123) begin
      miscompares++;
      $display("FAIL clear_latency: counter=%0d expected 123", counter);
    end
    @(negedge clk);
    vectors++;
    if (counter !== 14'd0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_stop: counter=%0d running=%b expected 0 0", counter, running);
    end
    exp_count = 0;
    repeat (10) @(negedge clk);
    vectors++;
    if (counter !== 14'd0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_to_stop: counter=%0d running=%b expected 0 0", counter, running);
    end
  endtask

  task automatic test_clear_run;
    pulse(B_RUN);
    exp_q.push_back(1);
    exp_q.push_back(2);
    @(negedge clk);
    pulse(B_CLR);
    vectors++;
    if (running !== 1'b1 || counter !== 14'd1) begin
      miscompares++;
      $display("FAIL clear_in_run: running=%b counter=%0d expected 1 1", running, counter);
    end
    pulse(B_RUN);
    exp_count = 2;
    vectors++;
    if (running !== 1'b0 || counter !== 14'd2 || tick !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_run_stop: running=%b counter=%0d tick=%b expected 0 2 0",
               running, counter, tick);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL clear_run_missing_ticks: pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_both;
    pulse(B_RUN | B_CLR);
    vectors++;
    if (counter !== 14'd2 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL both_stop_enter: counter=%0d running=%b expected 2 0", counter, running);
    end
    @(negedge clk);
    vectors++;
    if (counter !== 14'd0) begin
      miscompares++;
      $display("FAIL both_stop_clear: counter=%0d expected 0", counter);
    end
    exp_count = 0;
    repeat (6) @(negedge clk);
    run_then_stop(2, B_RUN | B_CLR, "both_run");
    repeat (3) @(negedge clk);
    vectors++;
    if (counter !== 14'd2 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL both_run_no_clear: counter=%0d running=%b expected 2 0", counter, running);
    end
  endtask

  task automatic test_wrap;
    pulse(B_CLR);
    repeat (6) @(negedge clk);
    exp_count = 0;
    pulse(B_MODE);
    exp_down = 1'b1;
    vectors++;
    if (mode_down !== 1'b1) begin
      miscompares++;
      $display("FAIL mode_to_down: mode_down=%b expected 1", mode_down);
    end
    run_then_stop(2, B_RUN, "down_wrap");
    vectors++;
    if (counter !== 14'd9998) begin
      miscompares++;
      $display("FAIL down_wrap_value: counter=%0d expected 9998", counter);
    end
    pulse(B_MODE);
    exp_down = 1'b0;
    vectors++;
    if (mode_down !== 1'b0) begin
      miscompares++;
      $display("FAIL mode_to_up: mode_down=%b expected 0", mode_down);
    end
    run_then_stop(3, B_RUN, "up_wrap");
    vectors++;
    if (counter !== 14'd1) begin
      miscompares++;
      $display("FAIL up_wrap_value: counter=%0d expected 1", counter);
    end
    pulse(B_MODE);
    exp_down = 1'b1;
    run_then_stop(3, B_RUN, "down_from_1");
  endtask

  task automatic test_reset_mid;
    bit seen_run;
    pulse(B_CLR);
    repeat (6) @(negedge clk);
    exp_count = 0;
    pulse(B_MODE);
    exp_down = 1'b0;
    run_then_stop(42, B_RUN, "to42");
    pulse(B_MODE);
    exp_down = 1'b1;
    pulse(B_RUN);
    exp_q.push_back(41);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (counter !== 14'd0 || running !== 1'b0 || mode_down !== 1'b0 || tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: counter=%0d running=%b mode_down=%b tick=%b expected 0 0 0 0",
               counter, running, mode_down, tick);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    exp_down = 1'b0;
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_missing_tick: pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
    btn_run_stop = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    btn_run_stop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_run = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (running === 1'b1) seen_run = 1'b1;
    end
    vectors++;
    if (seen_run !== 1'b0 || counter !== 14'd0) begin
      miscompares++;
      $display("FAIL pending_press_reset: running_seen=%b counter=%0d expected 0 0", seen_run, counter);
    end
    run_then_stop(2, B_RUN, "after_reset");
  endtask

  initial begin
    test_reset;
    test_run_press;
    test_bounce;
    test_clear_stop;
    test_clear_run;
    test_both;
    test_wrap;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
